// File: rtl/array_drain.sv
// array_drain: reader side of the DIMxDIM systolic array result bus.
// On start (in IDLE) the packed accumulator bus is snapshotted into a local
// buffer and then streamed one element per valid/ready handshake in
// row-major order, tagged with row/col and a last flag. hold is high while
// a frame is buffered or streaming.
// Optional macro DRAIN_RELU_EN: clamp negative (signed) elements to zero at
// capture time; when undefined the elements stream bit-exact.
//
// Handshake: out_valid, out_data, out_row, out_col and out_last are all
// registered. An element transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// every payload output holds its value. out_valid never drops before the
// transfer completes.
module array_drain #(
   parameter int DIM       = 4,
   parameter int ACC_WIDTH = 16,
   parameter int IDX_WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [ACC_WIDTH*DIM*DIM-1:0]   c_in,
   output logic                           hold,
   output logic [ACC_WIDTH-1:0]           out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$clog2(DIM)-1:0]         out_row,
   output logic [$clog2(DIM)-1:0]         out_col,
   output logic                           out_last,
   output logic                           done,
   output logic                           dbg_state
);

   localparam int N  = DIM * DIM;
   localparam int RW = $clog2(DIM);
   localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N - 1);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d, nidx;
   logic [ACC_WIDTH-1:0]   data_buf [N];
   logic [ACC_WIDTH-1:0]   data_d;
   logic [RW-1:0]          row_d, col_d;
   logic                   last_d, done_d, capture;

   // Element transform applied once, as the element enters the buffer.
   function automatic logic [ACC_WIDTH-1:0] relu(input logic [ACC_WIDTH-1:0] v);
`ifdef DRAIN_RELU_EN
      return v[ACC_WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign hold      = (state_q == STREAM);
   assign out_valid = (state_q == STREAM);
   assign dbg_state = (state_q == STREAM);

   // Next-state, next index and next registered payload.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = out_data;
      row_d   = out_row;
      col_d   = out_col;
      last_d  = out_last;
      done_d  = 1'b0;
      capture = 1'b0;
      nidx    = idx_q + IDX_WIDTH'(1);
      case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = STREAM;
               idx_d   = '0;
               data_d  = relu(c_in[ACC_WIDTH-1:0]);
               row_d   = '0;
               col_d   = '0;
               last_d  = (LAST == '0);
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (idx_q == LAST) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
                  data_d  = '0;
                  row_d   = '0;
                  col_d   = '0;
                  last_d  = 1'b0;
               end else begin
                  idx_d  = nidx;
                  data_d = data_buf[nidx];
                  row_d  = RW'(nidx / IDX_WIDTH'(DIM));
                  col_d  = RW'(nidx % IDX_WIDTH'(DIM));
                  last_d = (nidx == LAST);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, index, snapshot buffer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         out_data <= '0;
         out_row  <= '0;
         out_col  <= '0;
         out_last <= 1'b0;
         done     <= 1'b0;
         for (int k = 0; k < N; k++) data_buf[k] <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         out_data <= data_d;
         out_row  <= row_d;
         out_col  <= col_d;
         out_last <= last_d;
         done     <= done_d;
         if (capture) begin
            for (int k = 0; k < N; k++)
               data_buf[k] <= relu(c_in[ACC_WIDTH*k +: ACC_WIDTH]);
         end
      end
   end

endmodule

// File: tb/tb_array_drain.sv
// Directed bench for array_drain: reset, full drain, backpressure, capture
// isolation with start-while-busy, back-to-back start, reset mid-stream and
// the optional clamp (macro DRAIN_RELU_EN).
module tb_array_drain;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] c_in;
   logic         hold;
   logic [15:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   out_row;
   logic [1:0]   out_col;
   logic         out_last;
   logic         done;
   logic         dbg_state;

   int total = 0;
   int bad   = 0;
   logic [15:0] frame_exp [16];

   array_drain dut (
      .clk(clk), .rst(rst), .start(start), .c_in(c_in), .hold(hold),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .done(done), .dbg_state(dbg_state)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   // Advance past the next rising edge; sampling and driving happen here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] expect_val(input logic [15:0] v);
`ifdef DRAIN_RELU_EN
      return v[15] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   // Load c_in with element k = base + k and record the expected frame.
   task automatic load_ramp(input logic [15:0] base);
      for (int k = 0; k < 16; k++) begin
         c_in[16*k +: 16] = base + 16'(k);
         frame_exp[k]     = expect_val(base + 16'(k));
      end
   endtask

   task automatic chk_elem(input int k);
      chk($sformatf("data_k%0d", k), 32'(out_data), 32'(frame_exp[k]));
      chk($sformatf("row_k%0d", k), 32'(out_row), 32'(k / 4));
      chk($sformatf("col_k%0d", k), 32'(out_col), 32'(k % 4));
      chk($sformatf("last_k%0d", k), 32'(out_last), 32'(k == 15));
      chk($sformatf("valid_k%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold_k%0d", k), 32'(hold), 32'd1);
      chk($sformatf("done_k%0d", k), 32'(done), 32'd0);
   endtask

   // Drain elements from_k..15 with ready high, then check the done pulse.
   task automatic drain_rest(input int from_k);
      out_ready = 1'b1;
      for (int k = from_k; k < 16; k++) begin
         chk_elem(k);
         tick();
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("hold_after", 32'(hold), 32'd0);
      chk("valid_after", 32'(out_valid), 32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; c_in = '0;
      tick();
      rst = 1'b0;

      // Reset during activity: start a frame, stall it, then reset 3 cycles.
      load_ramp(16'h0100);
      pulse_start();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_data", 32'(out_data), 32'h0100);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_hold", 32'(hold), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_row", 32'(out_row), 32'd0);
      chk("rst_col", 32'(out_col), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      tick();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_valid", 32'(out_valid), 32'd0);

      // Full drain with ready held high: 16 consecutive cycles then done.
      out_ready = 1'b1;
      pulse_start();
      drain_rest(0);
      tick();
      chk("done_once", 32'(done), 32'd0);

      // Backpressure for 5 cycles while k=5 is presented.
      pulse_start();
      for (int k = 0; k < 16; k++) begin
         if (k == 5) begin
            out_ready = 1'b0;
            repeat (5) begin
               chk("bp_data", 32'(out_data), 32'h0105);
               chk("bp_row", 32'(out_row), 32'd1);
               chk("bp_col", 32'(out_col), 32'd1);
               chk("bp_valid", 32'(out_valid), 32'd1);
               tick();
            end
            out_ready = 1'b1;
         end
         chk_elem(k);
         tick();
      end
      chk("bp_done", 32'(done), 32'd1);
      tick();
      chk("bp_done_once", 32'(done), 32'd0);

      // Capture isolation and start while busy.
      pulse_start();
      c_in = {256{1'b1}};
      for (int k = 0; k < 16; k++) begin
         start = (k == 3);
         chk_elem(k);
         tick();
      end
      start = 1'b0;
      chk("iso_done", 32'(done), 32'd1);
      // Back-to-back: start accepted in the done cycle captures all-ones.
      pulse_start();
      for (int k = 0; k < 16; k++) frame_exp[k] = expect_val(16'hFFFF);
      chk("b2b_done_clear", 32'(done), 32'd0);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_data", 32'(out_data), 32'(expect_val(16'hFFFF)));

      // Advance to k=7, then reset mid-stream.
      for (int k = 0; k < 7; k++) begin
         chk_elem(k);
         tick();
      end
      chk("k7_row", 32'(out_row), 32'd1);
      chk("k7_col", 32'(out_col), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      load_ramp(16'h2000);
      pulse_start();
      chk("new_first_data", 32'(out_data), 32'h2000);
      chk("new_first_row", 32'(out_row), 32'd0);
      chk("new_first_col", 32'(out_col), 32'd0);
      drain_rest(0);
      tick();

      // Clamp behaviour on signed boundary values.
      c_in = '0;
      c_in[15:0]  = 16'hFFF0;
      c_in[31:16] = 16'h7FFF;
      c_in[47:32] = 16'h8000;
      pulse_start();
`ifdef DRAIN_RELU_EN
      chk("relu_e0", 32'(out_data), 32'h0000);
      tick();
      chk("relu_e1", 32'(out_data), 32'h7FFF);
      tick();
      chk("relu_e2", 32'(out_data), 32'h0000);
`else
      chk("raw_e0", 32'(out_data), 32'hFFF0);
      tick();
      chk("raw_e1", 32'(out_data), 32'h7FFF);
      tick();
      chk("raw_e2", 32'(out_data), 32'h8000);
`endif
      tick();
      chk("e3_zero", 32'(out_data), 32'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net against an unexpected stall of the directed sequence.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
